exp_result_collector: RTL and testbench
=======================================

Name: exp_result_collector

Overview:
Receives the exp stream (valid/data/done) produced by the exponent stage of the softmax pipeline and stores the number_of_data results in a local buffer. On request it replays the buffer to downstream consumers over a valid/ready handshake, in index order. Replay can repeat, so the sum pass and the normalise pass can both read the same exp values. It also flags protocol errors on the input side.

Parameters:
data_size, 32, width of one exp result word (IEEE-754 single, passed through untouched)
number_of_data, 10, number of results per vector; legal range 1..255

Ports:
clock_i  input  1  clock, all state on rising edge
reset_i  input  1  asynchronous, active-high reset
exp_data_i  input  data_size  exp result word from exponent stage
exp_data_valid_i  input  1  one-cycle qualifier for exp_data_i
exp_done_i  input  1  level from exponent stage, sticky high once all results are emitted
replay_start_i  input  1  one-cycle request to (re)start a replay
out_ready_i  input  1  downstream accepts current beat
out_data_o  output  data_size  replayed result word
out_data_valid_o  output  1  out_data_o/out_index_o/out_last_o valid
out_last_o  output  1  current beat is index number_of_data-1
out_index_o  output  8  index of current beat
collect_count_o  output  8  results stored so far
collect_full_o  output  1  buffer complete and done seen (states READY, REPLAY, DONE)
overflow_o  output  1  sticky: an input word was dropped
replay_done_o  output  1  high in DONE state
busy_o  output  1  high in REPLAY

Behaviour:
- Reset (asynchronous): state=COLLECT; wr_count=0; rd_idx=0; all buffer words=0; every output=0.
- States: COLLECT (reset state), READY, REPLAY, DONE.
- COLLECT:
  - exp_data_valid_i=1 and wr_count<number_of_data: write buffer[wr_count]; wr_count+1 on the same edge.
  - exp_data_valid_i=1 and wr_count==number_of_data: drop the word; set overflow_o.
  - Go to READY when wr_count==number_of_data and exp_done_i=1, evaluated on registered wr_count. A final write and done in the same cycle reach READY one cycle later.
  - exp_done_i=1 with wr_count<number_of_data: stay in COLLECT, no flag.
  - replay_start_i is ignored.
- READY: replay_start_i=1 → REPLAY with rd_idx=0.
- REPLAY:
  - Output registers load buffer[rd_idx] on entry. out_data_valid_o is high the cycle after replay_start_i is sampled (1-cycle latency).
  - While out_data_valid_o=1 and out_ready_i=0: out_data_o, out_index_o and out_last_o hold stable.
  - Beat accepted (valid & ready): rd_idx+1, and the next word is presented the following cycle with no bubble (back-to-back throughput 1 word/cycle).
  - out_last_o = (out_index_o==number_of_data-1).
  - Last beat accepted → DONE; out_data_valid_o drops the next cycle.
  - replay_start_i is ignored (including on the cycle the last beat is accepted).
- DONE: replay_done_o=1. replay_start_i=1 → REPLAY from index 0, same timing as READY. Replay count is unlimited.
- exp_data_valid_i=1 in READY, REPLAY or DONE: word dropped, overflow_o set; buffer never modified.
- overflow_o clears only on reset.
- collect_count_o = wr_count, saturates at number_of_data.
- out_index_o = rd_idx during REPLAY, 0 otherwise. out_data_o is 0 outside REPLAY.
- Reset asserted mid-replay: outputs drop asynchronously; after release the block is in COLLECT with an empty buffer.
- number_of_data=1: a single beat, out_last_o high on the first beat.

Test Plan:
- Feed 10 words 0x3F800000+i on consecutive cycles, then exp_done_i=1 → collect_count_o=10, collect_full_o=1 one cycle after done is seen; overflow_o=0.
- Pulse replay_start_i with out_ready_i=1 held → out_data_valid_o rises next cycle. 10 consecutive beats, indices 0..9, data 0x3F800000..0x3F800009, out_last_o only on index 9. replay_done_o=1 the cycle after the last beat.
- During replay, drive out_ready_i pseudo-randomly (stall 0–3 cycles) → data/index stable during every stall, no beat lost or duplicated, order preserved.
- After DONE, pulse replay_start_i again → identical 10-beat sequence. A replay_start_i pulsed mid-replay is ignored.
- Send 11 valid words then done → first 10 stored, collect_count_o=10, overflow_o=1 and sticky. A valid word in READY leaves buffer contents unchanged on replay.
- Assert reset_i at beat 4 of a replay → outputs 0 in the same cycle; after release state=COLLECT, collect_count_o=0, collect_full_o=0. Done asserted with only 7 words → stays in COLLECT.

Source files
------------

// File: rtl/exp_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : exp_result_collector
// Purpose  : Buffers one vector of exp results and replays it on demand over
//            a valid/ready handshake; flags dropped input words.
// Revision : 1.0 - initial release
// ============================================================================
module exp_result_collector #(
    parameter int DATA_SIZE      = 32,
    parameter int NUMBER_OF_DATA = 10
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [DATA_SIZE-1:0] exp_data_i,
    input  logic                 exp_data_valid_i,
    input  logic                 exp_done_i,
    input  logic                 replay_start_i,
    input  logic                 out_ready_i,
    output logic [DATA_SIZE-1:0] out_data_o,
    output logic                 out_data_valid_o,
    output logic                 out_last_o,
    output logic [7:0]           out_index_o,
    output logic [7:0]           collect_count_o,
    output logic                 collect_full_o,
    output logic                 overflow_o,
    output logic                 replay_done_o,
    output logic                 busy_o
);

    localparam int       c_aw    = (NUMBER_OF_DATA > 1) ? $clog2(NUMBER_OF_DATA) : 1;
    localparam logic [7:0] c_count = 8'(NUMBER_OF_DATA);
    localparam logic [7:0] c_last  = 8'(NUMBER_OF_DATA - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        READY   = 2'd1,
        REPLAY  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [DATA_SIZE-1:0] r_buffer [NUMBER_OF_DATA];
    logic [7:0]           r_wr_count;
    logic [7:0]           r_rd_idx;
    logic [DATA_SIZE-1:0] r_out_data;
    logic                 r_overflow;

    logic                 w_store;
    logic                 w_drop;
    logic                 w_start;
    logic                 w_accept;
    logic                 w_busy;
    logic [7:0]           w_next_idx;

    // The buffer is only written while collecting, so any word arriving
    // later (or beyond the vector length) is discarded and flagged.
    assign w_store    = (r_state == COLLECT) && exp_data_valid_i && (r_wr_count < c_count);
    assign w_drop     = exp_data_valid_i && !w_store;
    assign w_start    = ((r_state == READY) || (r_state == DONE)) && replay_start_i;
    assign w_busy     = (r_state == REPLAY);
    assign w_accept   = w_busy && out_ready_i;
    assign w_next_idx = r_rd_idx + 8'd1;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            COLLECT: begin
                if ((r_wr_count == c_count) && exp_done_i) begin
                    w_next_state = READY;
                end
            end
            READY, DONE: begin
                if (replay_start_i) begin
                    w_next_state = REPLAY;
                end
            end
            REPLAY: begin
                if (out_ready_i && (r_rd_idx == c_last)) begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = COLLECT;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUMBER_OF_DATA; i++) begin
                r_buffer[i] <= '0;
            end
            r_wr_count <= '0;
            r_rd_idx   <= '0;
            r_out_data <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_store) begin
                r_buffer[r_wr_count[c_aw-1:0]] <= exp_data_i;
                r_wr_count                     <= r_wr_count + 8'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            // Prefetch the next word on acceptance so beats stream without bubbles.
            if (w_start) begin
                r_rd_idx   <= '0;
                r_out_data <= r_buffer[0];
            end else if (w_accept && (r_rd_idx != c_last)) begin
                r_rd_idx   <= w_next_idx;
                r_out_data <= r_buffer[w_next_idx[c_aw-1:0]];
            end
        end
    end

    assign out_data_o       = w_busy ? r_out_data : '0;
    assign out_data_valid_o = w_busy;
    assign out_index_o      = w_busy ? r_rd_idx : 8'd0;
    assign out_last_o       = w_busy && (r_rd_idx == c_last);
    assign collect_count_o  = r_wr_count;
    assign collect_full_o   = (r_state != COLLECT);
    assign overflow_o       = r_overflow;
    assign replay_done_o    = (r_state == DONE);
    assign busy_o           = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_exp_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_exp_result_collector
// Purpose  : Directed self-checking bench for exp_result_collector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exp_result_collector;

    localparam int N = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] exp_data;
    logic        exp_valid;
    logic        exp_done;
    logic        start;
    logic        ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic [7:0]  out_index;
    logic [7:0]  count;
    logic        full;
    logic        overflow;
    logic        rdone;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    exp_result_collector #(.DATA_SIZE(32), .NUMBER_OF_DATA(N)) dut (
        .clock_i         (clk),
        .reset_i         (rst),
        .exp_data_i      (exp_data),
        .exp_data_valid_i(exp_valid),
        .exp_done_i      (exp_done),
        .replay_start_i  (start),
        .out_ready_i     (ready),
        .out_data_o      (out_data),
        .out_data_valid_o(out_valid),
        .out_last_o      (out_last),
        .out_index_o     (out_index),
        .collect_count_o (count),
        .collect_full_o  (full),
        .overflow_o      (overflow),
        .replay_done_o   (rdone),
        .busy_o          (busy)
    );

    typedef struct {
        logic        vld;
        logic [31:0] din;
        logic        done;
        logic        st;
        logic        rdy;
        logic [7:0]  e_cnt;
        logic        e_full;
        logic        e_vo;
        logic [7:0]  e_idx;
        logic [31:0] e_data;
        logic        e_last;
        logic        e_rdone;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(logic vld, logic [31:0] din, logic done, logic st, logic rdy,
                                logic [7:0] cnt, logic fl, logic vo, logic [7:0] idx,
                                logic [31:0] dat, logic last, logic rd);
        vec_t v;
        v.vld = vld; v.din = din; v.done = done; v.st = st; v.rdy = rdy;
        v.e_cnt = cnt; v.e_full = fl; v.e_vo = vo; v.e_idx = idx;
        v.e_data = dat; v.e_last = last; v.e_rdone = rd;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(int n, logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            exp_valid = 1'b1;
            exp_data  = base + 32'(i);
            tick();
        end
        exp_valid = 1'b0;
        exp_data  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_idx;
        int stall;
        int cyc;

        for (int i = 0; i < N; i++)
            tbl[i] = mk(1, 32'h3F800000 + 32'(i), 0, 0, 0, 8'(i + 1), 0, 0, 8'd0, 32'd0, 0, 0);
        tbl[10] = mk(0, 32'd0, 1, 0, 0, 8'd10, 1, 0, 8'd0, 32'd0, 0, 0);
        tbl[11] = mk(0, 32'd0, 1, 1, 1, 8'd10, 1, 1, 8'd0, 32'h3F800000, 0, 0);
        for (int k = 1; k < N; k++)
            tbl[11 + k] = mk(0, 32'd0, 1, 0, 1, 8'd10, 1, 1, 8'(k), 32'h3F800000 + 32'(k), k == N - 1, 0);
        tbl[21] = mk(0, 32'd0, 1, 0, 1, 8'd10, 1, 0, 8'd0, 32'd0, 0, 1);

        rst = 1'b1; exp_data = '0; exp_valid = 1'b0; exp_done = 1'b0; start = 1'b0; ready = 1'b0;
        #1;
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_count", {24'd0, count}, 32'd0);
        chk("reset_flags", {27'd0, full, overflow, rdone, busy, out_last}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Collection, first replay with ready held high.
        for (int r = 0; r < 22; r++) begin
            exp_valid = tbl[r].vld; exp_data = tbl[r].din; exp_done = tbl[r].done;
            start = tbl[r].st; ready = tbl[r].rdy;
            tick();
            chk($sformatf("t%0d_count", r), {24'd0, count}, {24'd0, tbl[r].e_cnt});
            chk($sformatf("t%0d_full", r), {31'd0, full}, {31'd0, tbl[r].e_full});
            chk($sformatf("t%0d_valid", r), {31'd0, out_valid}, {31'd0, tbl[r].e_vo});
            chk($sformatf("t%0d_busy", r), {31'd0, busy}, {31'd0, tbl[r].e_vo});
            chk($sformatf("t%0d_index", r), {24'd0, out_index}, {24'd0, tbl[r].e_idx});
            chk($sformatf("t%0d_data", r), out_data, tbl[r].e_data);
            chk($sformatf("t%0d_last", r), {31'd0, out_last}, {31'd0, tbl[r].e_last});
            chk($sformatf("t%0d_rdone", r), {31'd0, rdone}, {31'd0, tbl[r].e_rdone});
            chk($sformatf("t%0d_ovf", r), {31'd0, overflow}, 32'd0);
        end
        exp_valid = 1'b0; start = 1'b0;

        // Second replay under random stalls; start pulses mid-replay and on the last beat.
        start = 1'b1; ready = 1'b0;
        tick();
        start = 1'b0;
        exp_idx = 0; stall = 0; cyc = 0;
        while (exp_idx < N && cyc < 200) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_index", {24'd0, out_index}, 32'(exp_idx));
            chk("stall_data", out_data, 32'h3F800000 + 32'(exp_idx));
            chk("stall_last", {31'd0, out_last}, {31'd0, exp_idx == N - 1});
            if (stall > 0) begin
                ready = 1'b0;
                stall--;
            end else begin
                ready = 1'b1;
                stall = $urandom_range(0, 3);
            end
            start = (exp_idx == 3) || (ready && exp_idx == N - 1);
            tick();
            if (ready) exp_idx++;
            cyc++;
        end
        start = 1'b0;
        chk("stall_beats", 32'(exp_idx), 32'(N));
        chk("stall_end_rdone", {31'd0, rdone}, 32'd1);
        chk("stall_end_valid", {31'd0, out_valid}, 32'd0);

        // Reset during beat 4 of a replay.
        start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("prerst_index", {24'd0, out_index}, 32'(k));
            if (k < 4) tick();
        end
        rst = 1'b1;
        #1;
        chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_async_data", out_data, 32'd0);
        chk("rst_async_index", {24'd0, out_index}, 32'd0);
        tick();
        rst = 1'b0; ready = 1'b0; exp_done = 1'b0;
        tick();
        chk("postrst_count", {24'd0, count}, 32'd0);
        chk("postrst_full", {31'd0, full}, 32'd0);
        chk("postrst_ovf", {31'd0, overflow}, 32'd0);

        // Eleven words: the last is dropped and the flag sticks.
        feed(N + 1, 32'h40000000);
        chk("ovf_count", {24'd0, count}, 32'(N));
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        exp_done = 1'b1;
        tick();
        chk("ovf_full", {31'd0, full}, 32'd1);
        exp_valid = 1'b1; exp_data = 32'hBAD0BAD0;
        tick();
        exp_valid = 1'b0;
        start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk("ovf_replay_data", out_data, 32'h40000000 + 32'(k));
            tick();
        end
        chk("ovf_replay_rdone", {31'd0, rdone}, 32'd1);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Done with only seven words stays in COLLECT.
        exp_done = 1'b0; ready = 1'b0;
        do_reset();
        feed(7, 32'h3F000000);
        exp_done = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("short_count", {24'd0, count}, 32'd7);
        chk("short_full", {31'd0, full}, 32'd0);
        chk("short_busy", {31'd0, busy}, 32'd0);
        chk("short_ovf", {31'd0, overflow}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
